// File: rtl/serial_subtractor_pkg.sv
// Shared types and the one-bit full-subtractor used by the serial subtractor datapath.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-bit full subtractor: returns {borrow_out, diff}.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bw);
    logic diff_v;
    logic bw_v;
    diff_v = a ^ b ^ bw;
    bw_v   = (~a & b) | (~(a ^ b) & bw);
    return {bw_v, diff_v};
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the serial subtractor.
// master = producer/consumer side, slave = the subtractor itself.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             b_out;
  logic             ovf;

  modport master (
    output in_valid, x, y, b_in, out_ready,
    input  in_ready, out_valid, d, b_out, ovf
  );

  modport slave (
    input  in_valid, x, y, b_in, out_ready,
    output in_ready, out_valid, d, b_out, ovf
  );
endinterface

// File: rtl/serial_subtractor_sub_digit.sv
// Combinational DIGIT-bit ripple-borrow subtractor slice.
module sub_digit
  import serial_sub_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bw_in,
  output logic [DIGIT-1:0] diff,
  output logic             bw_out
);

  logic [DIGIT:0] chain_s;
  logic [1:0]     bit_s;

  // Ripple the borrow from the slice LSB up to its MSB.
  always_comb begin
    chain_s    = '0;
    diff       = '0;
    bit_s      = 2'b00;
    chain_s[0] = bw_in;
    for (int i = 0; i < DIGIT; i++) begin
      bit_s        = full_sub(a[i], b[i], chain_s[i]);
      diff[i]      = bit_s[0];
      chain_s[i+1] = bit_s[1];
    end
    bw_out = chain_s[DIGIT];
  end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: d = x - y - b_in, DIGIT bits per clock, LSB first.
// Results shift in from the MSB side so d is aligned after the last step.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int NSTEPS = WIDTH / DIGIT;
  localparam int CNT_W  = $clog2(NSTEPS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSTEPS - 1);

  if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $fatal(1, "serial_subtractor: WIDTH must be >= 2 and divisible by DIGIT >= 1");
  end

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] x_sh_r;
  logic [WIDTH-1:0] y_sh_r;
  logic [WIDTH-1:0] d_r;
  logic             bw_r;
  logic             x_msb_r;
  logic             y_msb_r;
  logic             b_out_r;
  logic             ovf_r;
  logic             accept_s;
  logic             last_s;
  logic [DIGIT-1:0] diff_s;
  logic             bw_out_s;
  logic [WIDTH-1:0] d_shift_s;

  sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
    .a      (x_sh_r[DIGIT-1:0]),
    .b      (y_sh_r[DIGIT-1:0]),
    .bw_in  (bw_r),
    .diff   (diff_s),
    .bw_out (bw_out_s)
  );

  // New slice enters d from the MSB side; with a single step it is the whole result.
  if (DIGIT == WIDTH) begin : g_single_step
    assign d_shift_s = diff_s;
  end else begin : g_multi_step
    assign d_shift_s = {diff_s, d_r[WIDTH-1:DIGIT]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode plus accept/last-step strobes for the datapath.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid && rst_n) begin
          accept_s    = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_CNT) begin
          last_s      = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Operand capture, digit-serial shifting and final flag registration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      x_sh_r  <= '0;
      y_sh_r  <= '0;
      d_r     <= '0;
      bw_r    <= 1'b0;
      x_msb_r <= 1'b0;
      y_msb_r <= 1'b0;
      b_out_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            x_sh_r  <= bus.x;
            y_sh_r  <= bus.y;
            bw_r    <= bus.b_in;
            cnt_r   <= '0;
            x_msb_r <= bus.x[WIDTH-1];
            y_msb_r <= bus.y[WIDTH-1];
          end
        end
        RUN: begin
          x_sh_r <= x_sh_r >> DIGIT;
          y_sh_r <= y_sh_r >> DIGIT;
          d_r    <= d_shift_s;
          bw_r   <= bw_out_s;
          cnt_r  <= cnt_r + CNT_W'(1);
          if (last_s) begin
            b_out_r <= bw_out_s;
            // Overflow only when operand signs differ and the result sign departs from x.
            ovf_r   <= (x_msb_r != y_msb_r) && (diff_s[DIGIT-1] != x_msb_r);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == IDLE) && rst_n;
  assign bus.out_valid = (state_r == DONE);
  assign bus.d         = d_r;
  assign bus.b_out     = b_out_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: one DUT with DIGIT=1, one with DIGIT=4.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) if1 ();
  serial_subtractor_if #(.WIDTH(8)) if4 ();

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  typedef struct packed {
    logic [7:0] d;
    logic       b;
    logic       o;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  function automatic logic f_ready(input int sel);
    return (sel == 1) ? if1.in_ready : if4.in_ready;
  endfunction

  function automatic logic f_valid(input int sel);
    return (sel == 1) ? if1.out_valid : if4.out_valid;
  endfunction

  function automatic logic [7:0] f_d(input int sel);
    return (sel == 1) ? if1.d : if4.d;
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [7:0] xv, input logic [7:0] yv,
                        input logic bv);
    if (sel == 1) begin
      if1.in_valid = v; if1.x = xv; if1.y = yv; if1.b_in = bv;
    end else begin
      if4.in_valid = v; if4.x = xv; if4.y = yv; if4.b_in = bv;
    end
  endtask

  task automatic set_ordy(input int sel, input logic v);
    if (sel == 1) if1.out_ready = v;
    else          if4.out_ready = v;
  endtask

  // Result monitor: pops the expected response whenever a result is handed over.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && if1.out_valid && if1.out_ready) begin
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL d1_unexpected_result: got d=%0h expected no result", if1.d);
      end else begin
        e = q1.pop_front();
        chk("d1_d", if1.d, e.d);
        chk("d1_b_out", 8'(if1.b_out), 8'(e.b));
        chk("d1_ovf", 8'(if1.ovf), 8'(e.o));
      end
    end
    if (rst_n && if4.out_valid && if4.out_ready) begin
      if (q4.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL d4_unexpected_result: got d=%0h expected no result", if4.d);
      end else begin
        e = q4.pop_front();
        chk("d4_d", if4.d, e.d);
        chk("d4_b_out", 8'(if4.b_out), 8'(e.b));
        chk("d4_ovf", 8'(if4.ovf), 8'(e.o));
      end
    end
  end

  // One operation: wait for in_ready, hand operands over, check latency, optionally stall in DONE.
  task automatic op(input int sel, input logic [7:0] xv, input logic [7:0] yv, input logic bv,
                    input logic [7:0] ed, input logic eb, input logic eo, input int hold);
    int   cyc;
    int   ns;
    exp_t e;
    e.d = ed; e.b = eb; e.o = eo;
    ns  = (sel == 1) ? 8 : 2;
    cyc = 0;
    while (!f_ready(sel) && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    if (!f_ready(sel)) begin
      n_cmp++; n_bad++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 20 cycles");
      return;
    end
    if (hold > 0) set_ordy(sel, 1'b0);
    set_in(sel, 1'b1, xv, yv, bv);
    if (sel == 1) q1.push_back(e);
    else          q4.push_back(e);
    @(posedge clk); #1;
    set_in(sel, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc = 0;
    while (!f_valid(sel) && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk("latency", 8'(cyc), 8'(ns));
    if (hold > 0) begin
      set_in(sel, 1'b1, 8'h33, 8'h11, 1'b1);
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        chk("hold_d_stable", f_d(sel), ed);
        chk("hold_in_ready", 8'(f_ready(sel)), 8'h00);
        chk("hold_out_valid", 8'(f_valid(sel)), 8'h01);
      end
      set_in(sel, 1'b0, 8'h00, 8'h00, 1'b0);
      set_ordy(sel, 1'b1);
      @(posedge clk); #1;
      chk("release_in_ready", 8'(f_ready(sel)), 8'h01);
      chk("release_out_valid", 8'(f_valid(sel)), 8'h00);
      repeat (3) @(posedge clk);
      #1;
      chk("ignored_in_valid", 8'(f_ready(sel)), 8'h01);
    end
  endtask

  initial begin : stim
    int seen_valid;
    set_in(1, 1'b0, 8'h00, 8'h00, 1'b0);
    set_in(4, 1'b0, 8'h00, 8'h00, 1'b0);
    set_ordy(1, 1'b1);
    set_ordy(4, 1'b1);

    // Reset state
    #12;
    chk("rst_in_ready", 8'(if1.in_ready), 8'h00);
    chk("rst_out_valid", 8'(if1.out_valid), 8'h00);
    chk("rst_d", if1.d, 8'h00);
    chk("rst_b_out", 8'(if1.b_out), 8'h00);
    chk("rst_ovf", 8'(if1.ovf), 8'h00);
    chk("rst4_in_ready", 8'(if4.in_ready), 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 8'(if1.in_ready), 8'h01);
    chk("post_rst_out_valid", 8'(if1.out_valid), 8'h00);

    // DIGIT=1 arithmetic
    op(1, 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 0);
    op(1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 0);
    op(1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);
    op(1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 0);
    op(1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);

    // DIGIT=4 arithmetic
    op(4, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 0);
    op(4, 8'h3C, 8'h5A, 1'b0, 8'hE2, 1'b1, 1'b0, 0);
    op(4, 8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b1, 0);

    // Stall in DONE for 5 cycles
    op(1, 8'hC3, 8'h3C, 1'b0, 8'h87, 1'b0, 1'b0, 5);

    // Abort mid-RUN with reset
    set_in(1, 1'b1, 8'h5A, 8'h3C, 1'b0);
    @(posedge clk); #1;
    set_in(1, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 8'(if1.in_ready), 8'h00);
    chk("abort_out_valid", 8'(if1.out_valid), 8'h00);
    chk("abort_d", if1.d, 8'h00);
    chk("abort_b_out", 8'(if1.b_out), 8'h00);
    chk("abort_ovf", 8'(if1.ovf), 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_valid = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (if1.out_valid) seen_valid = 1;
    end
    chk("abort_no_out_valid", 8'(seen_valid), 8'h00);
    chk("abort_idle", 8'(if1.in_ready), 8'h01);

    // Recovery after abort
    op(1, 8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b1, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("q1_drained", 8'(q1.size()), 8'h00);
    chk("q4_drained", 8'(q4.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
